// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: mode and state encodings plus the select-width helper shared by scan_mux and its bench
package scan_mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  function automatic int sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/scan_mux_rr_pick.sv
// rr_pick: combinational round-robin search, first set bit of en at or after ptr wrapping modulo CHANNELS (in: en, ptr; out: found, idx)
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W = 2
) (
  input  logic [CHANNELS-1:0] en,
  input  logic [SEL_W-1:0]    ptr,
  output logic                found,
  output logic [SEL_W-1:0]    idx
);
  logic [SEL_W-1:0] c;
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      c = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (en[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered channel mux with direct/round-robin select and ready handshake (in: clk, rst, mode, sel, en, d, out_ready; out: o, o_valid, o_ch)
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          o,
  output logic                      o_valid,
  output logic [SEL_W-1:0]          o_ch
);
  logic [0:0] state;
  logic [SEL_W-1:0] ptr, rr_idx, cand_idx, ptr_nxt;
  logic rr_found, sel_ok, cand, load;
  logic [WIDTH-1:0] cand_d;
  rr_pick #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_pick (
    .en(en),
    .ptr(ptr),
    .found(rr_found),
    .idx(rr_idx)
  );
  always_comb begin
    sel_ok = (int'(sel) < CHANNELS) ? en[sel] : 1'b0;
    cand = (mode == MODE_SCAN) ? rr_found : sel_ok;
    cand_idx = (mode == MODE_SCAN) ? rr_idx : sel;
    cand_d = d[int'(cand_idx)*WIDTH +: WIDTH];
    load = (state == EMPTY) | out_ready;
    ptr_nxt = (int'(cand_idx) == CHANNELS - 1) ? '0 : cand_idx + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      o <= '0;
      o_ch <= '0;
      ptr <= '0;
    end else begin
      if (load) begin
        state <= cand ? FULL : EMPTY;
        if (cand) begin
          o <= cand_d;
          o_ch <= cand_idx;
        end
      end
      if (mode == MODE_DIRECT) ptr <= '0;
      else if (load && cand) ptr <= ptr_nxt;
    end
  end
  assign o_valid = (state == FULL);
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed self-checking bench for scan_mux (4-channel and 3-channel instances)
module tb_scan_mux;
  import scan_mux_pkg::*;
  logic clk, rst;
  logic mode, out_ready;
  logic [1:0] sel;
  logic [3:0] en;
  logic [15:0] d;
  logic [3:0] o;
  logic o_valid;
  logic [1:0] o_ch;
  logic mode3, out_ready3;
  logic [1:0] sel3;
  logic [2:0] en3;
  logic [11:0] d3;
  logic [3:0] o3;
  logic o_valid3;
  logic [1:0] o_ch3;
  int checks, errors;

  scan_mux #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .en(en), .d(d),
    .out_ready(out_ready), .o(o), .o_valid(o_valid), .o_ch(o_ch)
  );
  scan_mux #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .en(en3), .d(d3),
    .out_ready(out_ready3), .o(o3), .o_valid(o_valid3), .o_ch(o_ch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic v, input logic [3:0] eo, input logic [1:0] ech);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    check({tag, ".o"}, 32'(o), 32'(eo));
    check({tag, ".ch"}, 32'(o_ch), 32'(ech));
  endtask

  initial begin
    logic [3:0] exp_o3 [4];
    logic [3:0] dir_o [4];
    logic [1:0] scan_ch [6];
    logic [3:0] scan_o [6];
    checks = 0;
    errors = 0;
    exp_o3 = '{4'hA, 4'hB, 4'hC, 4'hA};
    dir_o = '{4'hA, 4'hB, 4'hC, 4'hD};
    scan_ch = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    scan_o = '{4'hA, 4'hB, 4'hD, 4'hA, 4'hB, 4'hD};
    rst = 1'b1;
    mode = MODE_DIRECT;
    sel = 2'd0;
    en = 4'hF;
    d = 16'hDCBA;
    out_ready = 1'b1;
    mode3 = MODE_SCAN;
    sel3 = 2'd0;
    en3 = 3'b111;
    d3 = 12'hCBA;
    out_ready3 = 1'b1;
    #2;
    chk("reset", 1'b0, 4'h0, 2'd0);
    check("reset3.valid", 32'(o_valid3), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      chk($sformatf("direct%0d", i), 1'b1, dir_o[i], 2'(i));
      check($sformatf("wrap3_ch%0d", i), 32'(o_ch3), 32'(i % 3));
      check($sformatf("wrap3_o%0d", i), 32'(o3), 32'(exp_o3[i]));
    end
    mode = MODE_SCAN;
    en = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("scan1011_%0d", i), 1'b1, scan_o[i], scan_ch[i]);
    end
    mode = MODE_DIRECT;
    sel = 2'd3;
    step();
    chk("reenter_direct", 1'b1, 4'hD, 2'd3);
    mode = MODE_SCAN;
    en = 4'hF;
    step();
    chk("stall_first", 1'b1, 4'hA, 2'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold%0d", i), 1'b1, 4'hA, 2'd0);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 1'b1, 4'hB, 2'd1);
    mode = MODE_DIRECT;
    sel = 2'd2;
    en = 4'b1011;
    step();
    chk("disabled_sel", 1'b0, 4'hB, 2'd1);
    en = 4'hF;
    step();
    chk("enabled_sel", 1'b1, 4'hC, 2'd2);
    out_ready = 1'b0;
    mode = MODE_SCAN;
    #3;
    rst = 1'b1;
    #2;
    chk("async_reset", 1'b0, 4'h0, 2'd0);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("after_reset", 1'b1, 4'hA, 2'd0);
    en = 4'h0;
    step();
    chk("scan_none", 1'b0, 4'hA, 2'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
